// File: rtl/conv_channel_accumulator.sv
// Output stage of the convolution datapath: sums NUM_CHANNELS partial sums plus a
// per-filter bias, then applies ReLU, a right-shift requantisation and unsigned saturation.
module conv_channel_accumulator #(
  parameter int IN_WIDTH     = 20,
  parameter int NUM_CHANNELS = 3,
  parameter int ACC_WIDTH    = 28,
  parameter int BIAS_WIDTH   = 16,
  parameter int SHIFT        = 4,
  parameter int OUT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic [BIAS_WIDTH-1:0] in_bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [7:0]            chan_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_ACT   = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(NUM_CHANNELS - 1);

  state_t                       state_q, state_d;
  logic [7:0]                   cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [OUT_WIDTH-1:0]         out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;

  logic signed [ACC_WIDTH-1:0]  data_ext_s;
  logic signed [ACC_WIDTH-1:0]  bias_ext_s;
  logic                         in_ready_s;
  logic                         accept_s;
  logic                         handshake_s;

  // ReLU, floor shift of the non-negative value, then clamp to the unsigned output range.
  function automatic logic [OUT_WIDTH-1:0] requant(input logic signed [ACC_WIDTH-1:0] acc);
    logic [ACC_WIDTH-1:0] r;
    logic [OUT_WIDTH-1:0] res;
    if (acc[ACC_WIDTH-1]) begin
      r = '0;
    end else begin
      r = $unsigned(acc >>> SHIFT);
    end
    if (r[ACC_WIDTH-1:OUT_WIDTH] != '0) begin
      res = {OUT_WIDTH{1'b1}};
    end else begin
      res = r[OUT_WIDTH-1:0];
    end
    return res;
  endfunction

  assign data_ext_s  = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
  assign bias_ext_s  = ACC_WIDTH'($signed(in_bias));
  assign in_ready_s  = enable & (state_q == ST_ACCUM) & ~clear;
  assign accept_s    = in_valid & in_ready_s;
  assign handshake_s = out_valid_q & out_ready & enable;

  // Next-state logic; clear wins over any handshake in the same cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (!enable) begin
      state_d = state_q;
    end else if (clear) begin
      state_d     = ST_ACCUM;
      cnt_d       = 8'd0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACCUM;
        end
        ST_ACCUM: begin
          if (accept_s) begin
            acc_d = ((cnt_q == 8'd0) ? bias_ext_s : acc_q) + data_ext_s;
            if (cnt_q == LAST_CNT) begin
              state_d = ST_ACT;
              cnt_d   = 8'd0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            acc_d = acc_q;
          end
        end
        ST_ACT: begin
          out_data_d  = requant(acc_q);
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
        ST_HOLD: begin
          if (handshake_s) begin
            out_valid_d = 1'b0;
            state_d     = ST_ACCUM;
          end else begin
            out_valid_d = 1'b1;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          cnt_d       = 8'd0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign chan_cnt  = cnt_q;

endmodule

// File: tb/tb_conv_channel_accumulator.sv
// Bench for conv_channel_accumulator: directed vectors with literal expectations plus
// randomized traffic, all checked every cycle against a pixel-level reference model.
module tb_conv_channel_accumulator;

  localparam int NC = 3;
  localparam int SH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [19:0] in_data = 20'd0;
  logic [15:0] in_bias = 16'd0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [7:0]  chan_cnt;

  int tests = 0;
  int fails = 0;
  longint log_q[$];

  // Reference model: pixel progress, running sum and the pending result.
  bit     m_started;
  int     m_cnt;
  longint m_sum;
  int     m_wait;   // 0 none, 1 result being computed, 2 result presented
  longint m_out;

  conv_channel_accumulator #(
    .IN_WIDTH(20), .NUM_CHANNELS(NC), .ACC_WIDTH(28),
    .BIAS_WIDTH(16), .SHIFT(SH), .OUT_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_bias(in_bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .chan_cnt(chan_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic longint requant_model(longint s);
    longint r;
    if (s < 0) r = 0;
    else r = s / (longint'(1) << SH);
    if (r > 255) r = 255;
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_started <= 1'b0; m_cnt <= 0; m_sum <= 0; m_wait <= 0; m_out <= 0;
    end else if (enable) begin
      if (!m_started) m_started <= 1'b1;
      else if (clear) begin
        m_cnt <= 0; m_wait <= 0;
      end else if (m_wait == 1) begin
        m_wait <= 2; m_out <= requant_model(m_sum);
      end else if (m_wait == 2) begin
        if (out_ready) m_wait <= 0;
      end else if (in_valid) begin
        m_sum <= ((m_cnt == 0) ? longint'($signed(in_bias)) : m_sum) + longint'($signed(in_data));
        if (m_cnt == NC - 1) begin
          m_cnt <= 0; m_wait <= 1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", longint'(in_ready), longint'(enable && m_started && m_wait == 0 && !clear));
    chk("out_valid", longint'(out_valid), longint'(m_wait == 2));
    chk("chan_cnt", longint'(chan_cnt), longint'(m_cnt));
    if (m_wait == 2) chk("out_data", longint'(out_data), m_out);
    if (out_valid && out_ready && enable && !clear && !reset) log_q.push_back(longint'(out_data));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int d, input int b);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = 20'(d);
    in_bias  = 16'(b);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready && enable;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("beat_accept", longint'(ok), 1);
  endtask

  task automatic wait_out(output longint v);
    int n;
    n = log_q.size();
    for (int i = 0; i < 200 && log_q.size() == n; i++) tick();
    chk("out_arrived", longint'(log_q.size() > n), 1);
    v = (log_q.size() > n) ? log_q[$] : -1;
  endtask

  task automatic send_pixel(input int b, input int d0, input int d1, input int d2, output longint v);
    send_beat(d0, b);
    send_beat(d1, b);
    send_beat(d2, b);
    wait_out(v);
  endtask

  initial begin
    longint v;
    int n;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_chan_cnt", longint'(chan_cnt), 0);
    #2 reset = 1'b0;
    tick();

    // basic vector: 40+100+200+300 = 640, 640>>4 = 40; latency check
    send_beat(100, 40);
    send_beat(200, 40);
    send_beat(300, 40);
    chk("lat_accept_edge", longint'(out_valid), 0);
    tick();
    chk("lat_second_edge", longint'(out_valid), 1);
    wait_out(v);
    chk("basic", v, 40);

    n = log_q.size();
    send_pixel(0, -500, 100, 50, v);
    chk("relu", v, 0);
    repeat (3) tick();
    chk("relu_single_out", longint'(log_q.size()), longint'(n + 1));

    send_pixel(16'h7FFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, v);
    chk("saturate", v, 255);

    // backpressure
    out_ready = 1'b0;
    send_beat(100, 40);
    send_beat(200, 40);
    send_beat(300, 40);
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", longint'(out_valid), 1);
      chk("bp_data", longint'(out_data), 40);
      chk("bp_in_ready", longint'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    wait_out(v);
    chk("bp_result", v, 40);
    chk("ready_after_hs", longint'(in_ready), 1);
    send_pixel(0, 16, 16, 16, v);
    chk("bp_second", v, 3);

    // stall between beats 1 and 2
    send_beat(100, 40);
    enable = 1'b0;
    repeat (4) tick();
    enable = 1'b1;
    send_beat(200, 40);
    send_beat(300, 40);
    wait_out(v);
    chk("stall", v, 40);

    // abort after two beats
    send_beat(7, 5);
    send_beat(9, 5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n = log_q.size();
    send_pixel(0, 160, 0, 0, v);
    chk("abort_result", v, 10);
    chk("abort_one_output", longint'(log_q.size()), longint'(n + 1));

    // asynchronous reset mid-pixel
    send_beat(50, 0);
    send_beat(60, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_out_valid", longint'(out_valid), 0);
    chk("arst_chan_cnt", longint'(chan_cnt), 0);
    chk("arst_in_ready", longint'(in_ready), 0);
    #3 reset = 1'b0;
    tick();
    n = log_q.size();
    send_pixel(0, 32, 32, 32, v);
    chk("post_reset", v, 6);
    chk("post_reset_count", longint'(log_q.size()), longint'(n + 1));

    // randomized traffic
    n = log_q.size();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'($urandom_range(0, 3300) - 300);
      in_bias   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 200));
      out_ready = ($urandom_range(0, 9) < 7);
      enable    = ($urandom_range(0, 9) < 9);
      clear     = ($urandom_range(0, 99) < 2);
      tick();
    end
    in_valid = 1'b0; clear = 1'b0; enable = 1'b1; out_ready = 1'b1;
    repeat (5) tick();
    chk("rand_outputs_seen", longint'(log_q.size() > n + 50), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
